// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, ALU op codes and ID/EX stage states
package pipe_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;
  localparam int SHW    = 6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_XOR = 3'b011,
    ALU_AND = 3'b100,
    ALU_CMP = 3'b101,
    ALU_SHL = 3'b110
  } alu_op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-side inputs, forwarding ports and ALU-side outputs
interface id_ex_stage_if import pipe_pkg::*; ();

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic              id_use_imm;
  logic [SHW-1:0]    id_shiftamt;
  logic [2:0]        id_sel;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic [XLEN-1:0]   ex_result;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [XLEN-1:0]   mem_result;
  logic              flush;
  logic              hold;
  logic              id_stall;
  logic [XLEN-1:0]   A;
  logic [XLEN-1:0]   B;
  logic [SHW-1:0]    Shiftamt;
  logic [2:0]        Sel;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [XLEN-1:0]   ex_store_data;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
           id_shiftamt, id_sel, id_rd, id_reg_write, id_mem_read, id_mem_write,
           ex_result, mem_rd, mem_reg_write, mem_result, flush, hold,
    input  id_stall, A, B, Shiftamt, Sel, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
           id_shiftamt, id_sel, id_rd, id_reg_write, id_mem_read, id_mem_write,
           ex_result, mem_rd, mem_reg_write, mem_result, flush, hold,
    output id_stall, A, B, Shiftamt, Sel, ex_valid, ex_rd, ex_reg_write,
           ex_mem_read, ex_mem_write, ex_store_data
  );

endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// rtl/id_ex_stage_fwd_mux.sv - per-source operand forwarding, EX over MEM over register file
module fwd_mux import pipe_pkg::*; (
  input  logic [REG_AW-1:0] i_rs,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic              i_ex_fwd_en,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [XLEN-1:0]   i_ex_result,
  input  logic              i_mem_fwd_en,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [XLEN-1:0]   i_mem_result,
  output logic [XLEN-1:0]   o_data
);

  logic w_rs_nz;
  logic w_hit_ex;
  logic w_hit_mem;

  // x0 is hardwired zero, so a producer targeting it must never be forwarded
  assign w_rs_nz   = |i_rs;
  assign w_hit_ex  = w_rs_nz & i_ex_fwd_en  & (i_ex_rd  == i_rs);
  assign w_hit_mem = w_rs_nz & i_mem_fwd_en & (i_mem_rd == i_rs);

  assign o_data = w_hit_ex  ? i_ex_result  :
                  w_hit_mem ? i_mem_result : i_rf_data;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding and load-use stall
module id_ex_stage import pipe_pkg::*; (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  stage_state_e      r_state;
  stage_state_e      w_next_state;
  logic              r_valid;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [XLEN-1:0]   r_a;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_store_data;
  logic [SHW-1:0]    r_shamt;
  logic [2:0]        r_sel;

  logic              w_ex_fwd_en;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic              w_hazard;
  logic              w_stall;
  logic              w_load;
  logic              w_kill;

  // a load's result is not ready in EX; only ALU producers forward from there
  assign w_ex_fwd_en = r_valid & r_reg_write & ~r_mem_read;

  fwd_mux u_fwd_rs1 (
    .i_rs         (bus.id_rs1),
    .i_rf_data    (bus.id_rs1_data),
    .i_ex_fwd_en  (w_ex_fwd_en),
    .i_ex_rd      (r_rd),
    .i_ex_result  (bus.ex_result),
    .i_mem_fwd_en (bus.mem_reg_write),
    .i_mem_rd     (bus.mem_rd),
    .i_mem_result (bus.mem_result),
    .o_data       (w_fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .i_rs         (bus.id_rs2),
    .i_rf_data    (bus.id_rs2_data),
    .i_ex_fwd_en  (w_ex_fwd_en),
    .i_ex_rd      (r_rd),
    .i_ex_result  (bus.ex_result),
    .i_mem_fwd_en (bus.mem_reg_write),
    .i_mem_rd     (bus.mem_rd),
    .i_mem_result (bus.mem_result),
    .o_data       (w_fwd_rs2)
  );

  // rs2 only matters to an immediate-form instruction when it is a store
  assign w_hazard = r_valid & r_mem_read & (|r_rd) & bus.id_valid &
                    ((r_rd == bus.id_rs1) |
                     ((r_rd == bus.id_rs2) & (~bus.id_use_imm | bus.id_mem_write)));

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_load       = 1'b0;
    w_kill       = 1'b0;
    if (bus.flush) begin
      w_next_state = ST_RUN;
      w_kill       = 1'b1;
    end else if (bus.hold) begin
      w_stall = 1'b1;
    end else if ((r_state == ST_RUN) && w_hazard) begin
      w_stall      = 1'b1;
      w_kill       = 1'b1;
      w_next_state = ST_BUBBLE;
    end else begin
      w_next_state = ST_RUN;
      w_load       = bus.id_valid;
      w_kill       = ~bus.id_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_next_state;
  end

  // bubbles clear only valid and control; operand registers keep their last values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_store_data <= '0;
      r_shamt      <= '0;
      r_sel        <= '0;
    end else if (w_load) begin
      r_valid      <= 1'b1;
      r_rd         <= bus.id_rd;
      r_reg_write  <= bus.id_reg_write;
      r_mem_read   <= bus.id_mem_read;
      r_mem_write  <= bus.id_mem_write;
      r_a          <= w_fwd_rs1;
      r_b          <= bus.id_use_imm ? bus.id_imm : w_fwd_rs2;
      r_store_data <= w_fwd_rs2;
      r_shamt      <= bus.id_shiftamt;
      r_sel        <= bus.id_sel;
    end else if (w_kill) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end
  end

  assign bus.id_stall      = w_stall;
  assign bus.A             = r_a;
  assign bus.B             = r_b;
  assign bus.Shiftamt      = r_shamt;
  assign bus.Sel           = r_sel;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_reg_write  = r_valid & r_reg_write;
  assign bus.ex_mem_read   = r_valid & r_mem_read;
  assign bus.ex_mem_write  = r_valid & r_mem_write;
  assign bus.ex_store_data = r_store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with directed and random stimulus
module tb_id_ex_stage;
  import pipe_pkg::*;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sd;
    logic [5:0]  sh;
    logic [2:0]  sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));

  exp_t  m;
  bit    m_bub;
  exp_t  q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  logic  s_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] fwd(input logic [4:0] rs, input logic [63:0] rf);
    if (rs != 0 && m.valid && m.rw && !m.mr && m.rd == rs) return bus.ex_result;
    if (rs != 0 && bus.mem_reg_write && bus.mem_rd == rs)   return bus.mem_result;
    return rf;
  endfunction

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
    bus.id_shiftamt = 0; bus.id_sel = 0; bus.id_rd = 0; bus.id_reg_write = 0;
    bus.id_mem_read = 0; bus.id_mem_write = 0; bus.ex_result = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    bus.flush = 0; bus.hold = 0;
  endtask

  task automatic instr(input logic [4:0] rs1, rs2, rd, input logic [63:0] d1, d2,
                       input logic rw, mr, mw, ui, input logic [63:0] imm);
    bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_reg_write = rw;
    bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_use_imm = ui; bus.id_imm = imm;
    bus.id_sel = 3'($urandom_range(6, 0)); bus.id_shiftamt = 6'($urandom);
  endtask

  // Reference: decide this edge's outcome from the stage rules, then push it
  task automatic step();
    exp_t nx;
    logic haz;
    bit   nb;
    #1;
    haz = m.valid && m.mr && m.rd != 0 && bus.id_valid &&
          (m.rd == bus.id_rs1 || (m.rd == bus.id_rs2 && (!bus.id_use_imm || bus.id_mem_write)));
    s_stall = bus.flush ? 1'b0 : (bus.hold || (!m_bub && haz));
    chk("id_stall", bus.id_stall, s_stall);
    nx = m;
    nb = m_bub;
    if (bus.flush || (!bus.hold && !m_bub && haz) || (!bus.hold && !bus.id_valid)) begin
      nx.valid = 0; nx.rw = 0; nx.mr = 0; nx.mw = 0;
      nb = bus.flush ? 1'b0 : (bus.hold ? m_bub : (!m_bub && haz));
    end else if (!bus.hold) begin
      nx.valid = 1; nx.rd = bus.id_rd; nx.rw = bus.id_reg_write;
      nx.mr = bus.id_mem_read; nx.mw = bus.id_mem_write;
      nx.a = fwd(bus.id_rs1, bus.id_rs1_data);
      nx.sd = fwd(bus.id_rs2, bus.id_rs2_data);
      nx.b = bus.id_use_imm ? bus.id_imm : nx.sd;
      nx.sh = bus.id_shiftamt; nx.sel = bus.id_sel;
      nb = 0;
    end
    @(posedge clk);
    q.push_back(nx);
    m = nx;
    m_bub = nb;
    #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!bus.ex_valid)
        chk("bubble_flags", {61'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 64'd0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ctrl", {60'd0, bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write},
            {60'd0, e.valid, e.rw, e.mr, e.mw});
        if (e.valid) begin
          chk("A", bus.A, e.a);
          chk("B", bus.B, e.b);
          chk("store_data", bus.ex_store_data, e.sd);
          chk("rd_sh_sel", {50'd0, bus.ex_rd, bus.Shiftamt, bus.Sel}, {50'd0, e.rd, e.sh, e.sel});
        end
      end
    end
  end

  initial begin
    logic [63:0] a_hold;
    m = '{default: '0};
    m_bub = 0;
    idle();
    @(posedge clk); #1;
    chk("rst_A", bus.A, 0);
    chk("rst_B", bus.B, 0);
    chk("rst_valid", bus.ex_valid, 0);
    chk("rst_stall", bus.id_stall, 0);
    rst = 0;

    // plain capture
    instr(3, 4, 1, 64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 1, 0, 0, 0, 0);
    bus.id_sel = 3'b000;
    step();
    chk("cap_A", bus.A, 64'hAAAAAAAAAAAAAAAA);
    chk("cap_B", bus.B, 64'hBBBBBBBBBBBBBBBB);
    chk("cap_sel", bus.Sel, 0);
    chk("cap_valid", bus.ex_valid, 1);

    // forwarding priority
    instr(1, 2, 5, 64'h1, 64'h2, 1, 0, 0, 0, 0); step();
    instr(5, 2, 9, 64'h55, 64'h2, 1, 0, 0, 0, 0);
    bus.ex_result = 64'h11; bus.mem_rd = 5; bus.mem_reg_write = 1; bus.mem_result = 64'h22;
    step();
    chk("fwd_ex", bus.A, 64'h11);
    instr(5, 2, 0, 64'h55, 64'h2, 1, 0, 0, 0, 0); step();
    chk("fwd_mem", bus.A, 64'h22);
    instr(0, 2, 3, 64'h33, 64'h2, 1, 0, 0, 0, 0);
    bus.mem_rd = 0; bus.ex_result = 64'h44;
    step();
    chk("fwd_x0", bus.A, 64'h33);

    // load-use on rs2
    idle();
    instr(1, 2, 7, 64'h1, 64'h2, 1, 1, 0, 1, 64'h8); step();
    instr(1, 7, 10, 64'h1, 64'h99, 1, 0, 0, 0, 0);
    #1 chk("lu_stall", bus.id_stall, 1);
    step();
    chk("lu_bubble", bus.ex_valid, 0);
    bus.mem_rd = 7; bus.mem_reg_write = 1; bus.mem_result = 64'hDEAD;
    #1 chk("lu_stall_done", bus.id_stall, 0);
    step();
    chk("lu_B", bus.B, 64'hDEAD);
    chk("lu_valid", bus.ex_valid, 1);

    // immediate path ignores rs2 of a non-store
    idle();
    instr(1, 2, 7, 64'h1, 64'h2, 1, 1, 0, 1, 64'h8); step();
    instr(1, 7, 11, 64'h1, 64'h2, 1, 0, 0, 1, 64'hFFFFFFFFFFFFFFF0);
    step();
    chk("imm_B", bus.B, 64'hFFFFFFFFFFFFFFF0);
    chk("imm_valid", bus.ex_valid, 1);

    // hold freezes; flush beats hold and hazard
    idle();
    instr(1, 2, 6, 64'h1, 64'h2, 1, 1, 0, 1, 64'h8); step();
    a_hold = bus.A;
    instr(6, 2, 12, 64'h1, 64'h2, 1, 0, 0, 0, 0);
    bus.hold = 1;
    repeat (3) begin
      step();
      chk("hold_A", bus.A, a_hold);
      chk("hold_valid", bus.ex_valid, 1);
    end
    bus.flush = 1;
    step();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_rw", bus.ex_reg_write, 0);
    bus.flush = 0; bus.hold = 0;

    // async reset while in BUBBLE
    idle();
    instr(1, 2, 8, 64'h1, 64'h2, 1, 1, 0, 1, 64'h8); step();
    instr(8, 2, 13, 64'h1, 64'h2, 1, 0, 0, 0, 0); step();
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("arst_A", bus.A, 0);
    chk("arst_B", bus.B, 0);
    chk("arst_valid", bus.ex_valid, 0);
    chk("arst_rd", bus.ex_rd, 0);
    chk("arst_stall", bus.id_stall, 0);
    m = '{default: '0};
    m_bub = 0;
    @(posedge clk); #1;
    rst = 0;
    step();
    chk("arst_run_capture", bus.ex_valid, 1);

    // randomized traffic; decode re-presents its instruction while stalled
    s_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!s_stall) begin
        logic mr, mw;
        mr = ($urandom_range(3, 0) == 0);
        mw = !mr && ($urandom_range(7, 0) == 0);
        instr(5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)), 5'($urandom_range(7, 0)),
              {$urandom, $urandom}, {$urandom, $urandom},
              mr ? 1'b1 : (mw ? 1'b0 : 1'($urandom)), mr, mw, 1'($urandom), {$urandom, $urandom});
        bus.id_valid = ($urandom_range(4, 0) != 0);
      end
      bus.ex_result     = {$urandom, $urandom};
      bus.mem_rd        = 5'($urandom_range(7, 0));
      bus.mem_reg_write = 1'($urandom);
      bus.mem_result    = {$urandom, $urandom};
      bus.flush         = ($urandom_range(15, 0) == 0);
      bus.hold          = ($urandom_range(7, 0) == 0);
      step();
    end

    idle();
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
